wb_port_arbiter: RTL and testbench

Write-back port arbiter for the MIPS register file. Three requesters (ALU result, load data, link/MDU result) compete for the single register-file write port. The block grants one requester per cycle, drives the 2-bit select of the 3:1 5-bit write-address mux and the matching data mux, and registers the winning address/data into a one-cycle write stage. Bounded lock support lets a requester hold the port for back-to-back writes without starving the others.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_rr_pick.sv | 30 +++
 rtl/wb_port_arbiter.sv | 119 +++++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the register-file write-back port arbiter.
// Optional build macro WB_ARB_RR_EN selects round-robin arbitration (see wb_port_arbiter).
package wb_arb_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // One-hot grant to mux select; an empty grant selects nothing.
    function automatic logic [1:0] gnt2sel(input logic [NUM_REQ-1:0] g);
        if (g[0])      return SEL_REQ0;
        else if (g[1]) return SEL_REQ1;
        else if (g[2]) return SEL_REQ2;
        else           return SEL_NONE;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotate-priority picker: first candidate at or after ptr_i, wrapping modulo NUM_REQ.
module wb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    input  logic [NUM_REQ-1:0] excl_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [NUM_REQ-1:0] cand;
    logic               found;

    assign cand = req_i & ~excl_i;

    // Scan NUM_REQ positions starting from the pointer; take the first live candidate.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && cand[i] && (i == ((int'(ptr_i) + k) % NUM_REQ))) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: grants one of three requesters to the register-file
// write port each cycle, with bounded lock ownership, and registers the winner
// into a one-cycle write stage.
// Build macro WB_ARB_RR_EN: defined = round-robin pointer; undefined = fixed
// priority 0 > 1 > 2 (pointer tied to 0, not stored).
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic [AW-1:0]      waddr0,
    input  logic [AW-1:0]      waddr1,
    input  logic [AW-1:0]      waddr2,
    input  logic [DW-1:0]      wdata0,
    input  logic [DW-1:0]      wdata1,
    input  logic [DW-1:0]      wdata2,
    input  logic               rf_busy,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [1:0]         owner_q;      // SEL_NONE when no owner
    logic [CW-1:0]      lock_cnt_q;
    logic [1:0]         ptr;
    logic [NUM_REQ-1:0] own_oh, excl, pick;
    logic               own_act, others, at_max, cont, idle;
    logic [AW-1:0]      mux_addr;
    logic [DW-1:0]      mux_data;

    // Owner one-hot; shifting by SEL_NONE (3) falls off the vector and yields zero.
    assign own_oh  = NUM_REQ'(3'b001 << owner_q);
    assign own_act = |(own_oh & req & lock);
    assign others  = |(req & ~own_oh);
    assign at_max  = (lock_cnt_q == CW'(MAX_LOCK));
    // Continue the lock unless the bound is hit and someone else is waiting.
    assign cont    = own_act && (!at_max || !others);
    assign excl    = (own_act && at_max) ? own_oh : '0;
    assign idle    = rf_busy || !rst_n || (req == '0);

    wb_rr_pick u_pick (
        .req_i  (req),
        .ptr_i  (ptr),
        .excl_i (excl),
        .gnt_o  (pick)
    );

    // Grant is combinational from this cycle's request and the held state.
    always_comb begin
        gnt = '0;
        if (!idle) gnt = cont ? own_oh : pick;
    end

    assign sel = gnt2sel(gnt);

    // 3:1 address/data mux; no selection yields address 0 and zero data.
    always_comb begin
        mux_addr = '0;
        mux_data = '0;
        case (sel)
            SEL_REQ0: begin mux_addr = waddr0; mux_data = wdata0; end
            SEL_REQ1: begin mux_addr = waddr1; mux_data = wdata1; end
            SEL_REQ2: begin mux_addr = waddr2; mux_data = wdata2; end
            default:  begin mux_addr = '0;     mux_data = '0;     end
        endcase
    end

`ifdef WB_ARB_RR_EN
    logic [1:0] ptr_q;
    assign ptr = ptr_q;

    // Pointer moves past a requester only on a fresh (non-continuation) grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (|gnt && !cont) begin
            ptr_q <= (sel == SEL_REQ2) ? 2'd0 : sel + 2'd1;
        end
    end
`else
    assign ptr = 2'd0;
`endif

    // Ownership and lock count: hold on idle, count up on continuation, restart on new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= SEL_NONE;
            lock_cnt_q <= '0;
        end else if (|gnt) begin
            owner_q <= sel;
            if (!cont)       lock_cnt_q <= CW'(1);
            else if (!at_max) lock_cnt_q <= lock_cnt_q + CW'(1);
        end
    end

    // One-cycle write stage; writes to $0 are consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= |gnt && (mux_addr != '0);
            rf_waddr <= mux_addr;
            rf_wdata <= mux_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes expected grant and
// write-stage results; a negedge monitor pops and compares.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, lock;
    logic [4:0]  waddr0, waddr1, waddr2;
    logic [31:0] wdata0, wdata1, wdata2;
    logic        rf_busy;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .rf_busy(rf_busy), .gnt(gnt), .sel(sel),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  g;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t wr_q[$];
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    localparam logic [31:0] D0 = 32'h0000_00A0;
    localparam logic [31:0] D1 = 32'h0000_1234;
    localparam logic [31:0] D2 = 32'h0000_00C2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [2:0] g);
        case (g)
            3'b001:  return 2'b00;
            3'b010:  return 2'b01;
            3'b100:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Drive one cycle of inputs and record what the DUT must answer.
    task automatic step(input logic [2:0] r, input logic [2:0] l, input logic b,
                        input logic [2:0] eg, input logic ew, input logic [4:0] ea,
                        input logic [31:0] ed);
        exp_t e;
        @(posedge clk); #1;
        req = r; lock = l; rf_busy = b;
        e.g = eg; e.we = ew; e.a = ea; e.d = ed;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: first the write stage of the previous grant, then this cycle's grant.
    always @(negedge clk) begin
        exp_t w, e;
        if (mon_en) begin
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                chk("rf_we", {31'd0, rf_we}, {31'd0, w.we});
                if (w.we) begin
                    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, w.a});
                    chk("rf_wdata", rf_wdata, w.d);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", {29'd0, gnt}, {29'd0, e.g});
                chk("sel", {30'd0, sel}, {30'd0, exp_sel(e.g)});
                wr_q.push_back(e);
            end
        end
    end

    initial begin
        logic [2:0] rr [6];
`ifdef WB_ARB_RR_EN
        rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        rr = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        rst_n = 1'b0; req = 3'b111; lock = 3'b000; rf_busy = 1'b0;
        waddr0 = 5'd1; waddr1 = 5'd5; waddr2 = 5'd7;
        wdata0 = D0;   wdata1 = D1;   wdata2 = D2;

        // Reset state: no grant even with requests pending.
        #3;
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd3);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        @(posedge clk); #1;
        req = 3'b000; rst_n = 1'b1; mon_en = 1'b1;

        // All three requesting, no lock.
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 3'b000, 1'b0, rr[i], 1'b1,
                 rr[i] == 3'b001 ? 5'd1 : rr[i] == 3'b010 ? 5'd5 : 5'd7,
                 rr[i] == 3'b001 ? D0   : rr[i] == 3'b010 ? D1   : D2);
        end

        // Single request from requester 1.
        step(3'b010, 3'b000, 1'b0, 3'b010, 1'b1, 5'd5, D1);
        idle();

        // Lock bound: requester 0 holds four cycles, then requester 1 wins.
        for (int i = 0; i < 4; i++) step(3'b011, 3'b001, 1'b0, 3'b001, 1'b1, 5'd1, D0);
        step(3'b011, 3'b001, 1'b0, 3'b010, 1'b1, 5'd5, D1);

        // Sole locked requester past the bound keeps the port; count stays saturated.
        for (int i = 0; i < 6; i++) step(3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 5'd1, D0);
        step(3'b011, 3'b001, 1'b0, 3'b010, 1'b1, 5'd5, D1);
        idle();

        // Write to $0 is granted but not enabled.
        @(posedge clk); #1; waddr2 = 5'd0;
        step(3'b100, 3'b000, 1'b0, 3'b100, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1; waddr2 = 5'd7; req = 3'b000;
        exp_q.push_back('{g: 3'b000, we: 1'b0, a: 5'd0, d: 32'd0});

        // Register file busy for two cycles, grant on the first free cycle.
        step(3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 5'd0, 32'd0);
        step(3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 5'd0, 32'd0);
        step(3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 5'd1, D0);
        idle();

        // Reset in the middle of a locked burst.
        step(3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 5'd1, D0);
        step(3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 5'd1, D0);
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
        exp_q.delete(); wr_q.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, rf_we}, 32'd0);
        chk("midrst_gnt", {29'd0, gnt}, 32'd0);
        chk("midrst_sel", {30'd0, sel}, 32'd3);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; req = 3'b000; lock = 3'b000; mon_en = 1'b1;
        step(3'b110, 3'b000, 1'b0, 3'b010, 1'b1, 5'd5, D1);
        idle();
        idle();

        repeat (3) @(posedge clk);
        chk("queues_drained", exp_q.size() + wr_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
